// File: rtl/lenet5_pkg.sv
// Shared LeNet-5 image/kernel geometry and the window element index helper.
package lenet5_pkg;

  localparam int unsigned IMAGE_COLS = 32;
  localparam int unsigned IMAGE_ROWS = 32;
  localparam int unsigned PIXELWIDTH = 8;
  localparam int unsigned C1_KERNEL  = 5;
  localparam int unsigned C1_OUT_DIM = IMAGE_COLS - C1_KERNEL + 1;

  // Flat element index of window position (i,j); multiply by pixel width for the slice base.
  function automatic int unsigned win_index(input int unsigned i, input int unsigned j,
                                            input int unsigned k);
    return i * k + j;
  endfunction

endpackage

// File: rtl/conv_window_buffer_line_buffer.sv
// One-row delay line: single port addressed by column, asynchronous read, write at the same column.
module line_buffer #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Read returns the value stored one row earlier; the write lands on the same edge.
  assign rd_data = mem_q[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/conv_window_buffer.sv
// Sliding KERNEL x KERNEL window generator over a raster pixel stream, one window per valid position.
module conv_window_buffer #(
  parameter int unsigned IMAGE_COLS = lenet5_pkg::IMAGE_COLS,
  parameter int unsigned IMAGE_ROWS = lenet5_pkg::IMAGE_ROWS,
  parameter int unsigned PIXELWIDTH = lenet5_pkg::PIXELWIDTH,
  parameter int unsigned KERNEL     = lenet5_pkg::C1_KERNEL
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 pixel_valid,
  input  logic [PIXELWIDTH-1:0]                pixel_in,
  output logic [KERNEL*KERNEL*PIXELWIDTH-1:0]  window_out,
  output logic                                 window_valid,
  output logic [$clog2(IMAGE_ROWS)-1:0]        window_row,
  output logic [$clog2(IMAGE_COLS)-1:0]        window_col,
  output logic                                 frame_done
);
  import lenet5_pkg::*;

  localparam int unsigned CW    = $clog2(IMAGE_COLS);
  localparam int unsigned RW    = $clog2(IMAGE_ROWS);
  localparam int unsigned WIN_W = KERNEL * KERNEL * PIXELWIDTH;
  localparam int unsigned SH_W  = KERNEL * (KERNEL - 1) * PIXELWIDTH;
  localparam int unsigned NLB   = KERNEL - 1;

  logic [CW-1:0]         c_q, c_d;
  logic [RW-1:0]         r_q, r_d;
  logic [SH_W-1:0]       sh_q, sh_d;
  logic [WIN_W-1:0]      out_q, out_d;
  logic                  valid_q, valid_d;
  logic                  fd_q, fd_d;
  logic [RW-1:0]         row_q, row_d;
  logic [CW-1:0]         col_q, col_d;

  logic [PIXELWIDTH-1:0] lb_wr [NLB];
  logic [PIXELWIDTH-1:0] lb_rd [NLB];
  logic [PIXELWIDTH-1:0] col_px [KERNEL];
  logic [WIN_W-1:0]      win_next;

  for (genvar g = 0; g < NLB; g++) begin : g_lb
    line_buffer #(
      .DEPTH (IMAGE_COLS),
      .WIDTH (PIXELWIDTH)
    ) u_lb (
      .clk     (clk),
      .we      (pixel_valid),
      .addr    (c_q),
      .wr_data (lb_wr[g]),
      .rd_data (lb_rd[g])
    );
  end

  // Line buffer k holds row r-1-k; the window bottom row is the live pixel.
  always_comb begin
    for (int unsigned k = 0; k < NLB; k++) begin
      lb_wr[k] = (k == 0) ? pixel_in : lb_rd[(k == 0) ? 0 : k - 1];
    end
    for (int unsigned i = 0; i < KERNEL; i++) begin
      col_px[i] = (i == KERNEL - 1) ? pixel_in : lb_rd[(i == KERNEL - 1) ? 0 : KERNEL - 2 - i];
    end
  end

  // Shift register keeps only the KERNEL-1 older columns; the newest column comes straight in.
  always_comb begin
    win_next = '0;
    for (int unsigned i = 0; i < KERNEL; i++) begin
      for (int unsigned j = 0; j < KERNEL - 1; j++) begin
        win_next[win_index(i, j, KERNEL)*PIXELWIDTH +: PIXELWIDTH] =
          sh_q[(i*(KERNEL-1)+j)*PIXELWIDTH +: PIXELWIDTH];
      end
      win_next[win_index(i, KERNEL-1, KERNEL)*PIXELWIDTH +: PIXELWIDTH] = col_px[i];
    end
  end

  always_comb begin
    c_d     = c_q;
    r_d     = r_q;
    sh_d    = sh_q;
    out_d   = out_q;
    valid_d = 1'b0;
    fd_d    = 1'b0;
    row_d   = row_q;
    col_d   = col_q;
    if (pixel_valid) begin
      for (int unsigned i = 0; i < KERNEL; i++) begin
        for (int unsigned j = 0; j < KERNEL - 1; j++) begin
          sh_d[(i*(KERNEL-1)+j)*PIXELWIDTH +: PIXELWIDTH] =
            win_next[win_index(i, j+1, KERNEL)*PIXELWIDTH +: PIXELWIDTH];
        end
      end
      if (c_q == CW'(IMAGE_COLS - 1)) begin
        c_d = '0;
        r_d = (r_q == RW'(IMAGE_ROWS - 1)) ? '0 : r_q + 1'b1;
      end else begin
        c_d = c_q + 1'b1;
      end
      if (r_q >= RW'(KERNEL - 1) && c_q >= CW'(KERNEL - 1)) begin
        valid_d = 1'b1;
        out_d   = win_next;
        row_d   = r_q - RW'(KERNEL - 1);
        col_d   = c_q - CW'(KERNEL - 1);
        fd_d    = (r_q == RW'(IMAGE_ROWS - 1)) && (c_q == CW'(IMAGE_COLS - 1));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q     <= '0;
      r_q     <= '0;
      sh_q    <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      fd_q    <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      c_q     <= c_d;
      r_q     <= r_d;
      sh_q    <= sh_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      fd_q    <= fd_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  assign window_out   = out_q;
  assign window_valid = valid_q;
  assign window_row   = row_q;
  assign window_col   = col_q;
  assign frame_done   = fd_q;

endmodule

// File: tb/tb_conv_window_buffer.sv
// Directed bench for conv_window_buffer: image model in the bench produces every expected window.
module tb_conv_window_buffer;

  localparam int K    = 5;
  localparam int COLS = 32;
  localparam int ROWS = 32;
  localparam int PW   = 8;
  localparam int WW   = K * K * PW;

  logic          clk = 1'b0;
  logic          rst;
  logic          pixel_valid;
  logic [PW-1:0] pixel_in;
  logic [WW-1:0] window_out;
  logic          window_valid;
  logic [4:0]    window_row;
  logic [4:0]    window_col;
  logic          frame_done;

  int            errors = 0;
  int            checks = 0;
  int            er, ec;
  int            dut_wins, dut_fd;
  logic [WW-1:0] last_win;
  logic [4:0]    last_row, last_col;
  logic [PW-1:0] img [ROWS][COLS];

  always #5 clk = ~clk;

  conv_window_buffer #(
    .IMAGE_COLS (COLS),
    .IMAGE_ROWS (ROWS),
    .PIXELWIDTH (PW),
    .KERNEL     (K)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pixel_valid  (pixel_valid),
    .pixel_in     (pixel_in),
    .window_out   (window_out),
    .window_valid (window_valid),
    .window_row   (window_row),
    .window_col   (window_col),
    .frame_done   (frame_done)
  );

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [WW-1:0] exp_win(input int r, input int c);
    logic [WW-1:0] v;
    v = '0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        v[(i*K+j)*PW +: PW] = img[r-K+1+i][c-K+1+j];
    return v;
  endfunction

  function automatic logic [PW-1:0] elem(input logic [WW-1:0] v, input int i, input int j);
    return v[(i*K+j)*PW +: PW];
  endfunction

  task automatic push(input logic v, input logic [PW-1:0] p);
    logic expv, efd;
    pixel_valid = v;
    pixel_in    = p;
    @(posedge clk);
    #1;
    expv = 1'b0;
    efd  = 1'b0;
    if (v) begin
      img[er][ec] = p;
      if (er >= K-1 && ec >= K-1) begin
        expv     = 1'b1;
        efd      = (er == ROWS-1) && (ec == COLS-1);
        last_win = exp_win(er, ec);
        last_row = 5'(er - K + 1);
        last_col = 5'(ec - K + 1);
      end
      if (ec == COLS-1) begin
        ec = 0;
        er = (er == ROWS-1) ? 0 : er + 1;
      end else begin
        ec++;
      end
    end
    if (window_valid) dut_wins++;
    if (frame_done) dut_fd++;
    chk("window_valid", WW'(window_valid), WW'(expv));
    chk("window_out", window_out, last_win);
    chk("window_row", WW'(window_row), WW'(last_row));
    chk("window_col", WW'(window_col), WW'(last_col));
    chk("frame_done", WW'(frame_done), WW'(efd));
  endtask

  initial begin
    rst         = 1'b1;
    pixel_valid = 1'b0;
    pixel_in    = '0;
    er = 0; ec = 0;
    last_win = '0; last_row = '0; last_col = '0;
    dut_wins = 0; dut_fd = 0;
    #11;
    chk("reset_valid", WW'(window_valid), '0);
    chk("reset_fd", WW'(frame_done), '0);
    chk("reset_out", window_out, '0);
    chk("reset_row", WW'(window_row), '0);
    chk("reset_col", WW'(window_col), '0);
    #1 rst = 1'b0;

    // Frame 1: ramp, continuous valid
    for (int idx = 0; idx < ROWS*COLS; idx++) begin
      push(1'b1, 8'(idx));
      if (idx == 4*COLS+4) begin
        chk("first_valid", WW'(window_valid), WW'(1));
        chk("first_e00", WW'(elem(window_out, 0, 0)), WW'(0));
        chk("first_e04", WW'(elem(window_out, 0, 4)), WW'(4));
        chk("first_e40", WW'(elem(window_out, 4, 0)), WW'(128));
        chk("first_e44", WW'(elem(window_out, 4, 4)), WW'(132));
        chk("first_rc", WW'({window_row, window_col}), WW'(0));
      end
    end
    chk("last_e44", WW'(elem(window_out, 4, 4)), WW'(8'hFF));
    chk("last_row", WW'(window_row), WW'(27));
    chk("last_col", WW'(window_col), WW'(27));
    chk("last_fd", WW'(frame_done), WW'(1));
    chk("f1_windows", WW'(dut_wins), WW'(784));
    chk("f1_frame_done", WW'(dut_fd), WW'(1));

    // Frame 2: random image, back-to-back
    dut_wins = 0;
    for (int idx = 0; idx < ROWS*COLS; idx++) push(1'b1, 8'($urandom));
    chk("f2_windows", WW'(dut_wins), WW'(784));
    chk("f2_frame_done", WW'(dut_fd), WW'(2));

    // Frame 3: random image with ~40% idle cycles
    dut_wins = 0;
    for (int idx = 0; idx < ROWS*COLS; idx++) begin
      while ($urandom_range(0, 99) < 40) push(1'b0, 8'($urandom));
      push(1'b1, 8'($urandom));
    end
    push(1'b0, 8'h00);
    chk("f3_windows", WW'(dut_wins), WW'(784));
    chk("f3_frame_done", WW'(dut_fd), WW'(3));

    // Partial ramp to (10,7), then asynchronous reset while window_valid is high
    for (int idx = 0; idx <= 10*COLS+7; idx++) push(1'b1, 8'(idx));
    chk("pre_rst_valid", WW'(window_valid), WW'(1));
    #2 rst = 1'b1;
    #1;
    chk("async_valid", WW'(window_valid), '0);
    chk("async_fd", WW'(frame_done), '0);
    chk("async_out", window_out, '0);
    chk("async_row", WW'(window_row), '0);
    chk("async_col", WW'(window_col), '0);
    er = 0; ec = 0;
    last_win = '0; last_row = '0; last_col = '0;
    #1 rst = 1'b0;

    // Frame after reset: ramp again, coordinates restart at (0,0)
    dut_wins = 0;
    dut_fd   = 0;
    for (int idx = 0; idx < ROWS*COLS; idx++) begin
      push(1'b1, 8'(idx ^ 8'h5A));
      if (idx == 4*COLS+3) chk("post_rst_quiet", WW'(dut_wins), '0);
    end
    chk("f5_windows", WW'(dut_wins), WW'(784));
    chk("f5_frame_done", WW'(dut_fd), WW'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
